// File: rtl/done_tracker.sv
// Tracks result availability for rename tags 2..NFLAG+1: alloc clears a tag's done bit,
// execution write-back sets it, flush marks everything done. err latches protocol misuse.
module done_tracker #(
  parameter int TAG_W = 5,
  parameter int NFLAG = 30
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_valid_i,
  input  logic [TAG_W-1:0] alloc_tag_i,
  input  logic             wb0_valid_i,
  input  logic [TAG_W-1:0] wb0_tag_i,
  output logic             wb0_ready_o,
  input  logic             wb1_valid_i,
  input  logic [TAG_W-1:0] wb1_tag_i,
  output logic             wb1_ready_o,
  input  logic             flush_i,
  output logic [NFLAG-1:0] done_flags_o,
  output logic [4:0]       pending_count_o,
  output logic             err_o
);

  // Handshake: a write-back on port N is accepted in a cycle where wbN_valid_i and
  // wbN_ready_o are both high. Ready only drops for flush or reset; there is no
  // other back-pressure, and a valid with ready low is simply dropped.
  logic             ready;
  logic             alloc_en;
  logic             wb0_en;
  logic             wb1_en;

  logic [NFLAG-1:0] alloc_hit;
  logic [NFLAG-1:0] wb0_hit;
  logic [NFLAG-1:0] wb1_hit;

  logic [NFLAG-1:0] done_q;
  logic [NFLAG-1:0] done_d;
  logic [4:0]       cnt_q;
  logic [4:0]       cnt_d;
  logic             err_q;
  logic             err_d;

  assign ready       = !flush_i && !rst;
  assign wb0_ready_o = ready;
  assign wb1_ready_o = ready;

  assign alloc_en = alloc_valid_i && ready;
  assign wb0_en   = wb0_valid_i && ready;
  assign wb1_en   = wb1_valid_i && ready;

  // Per-tag decode; tags 0 and 1 have no flag bit and therefore never hit.
  always_comb begin
    alloc_hit = '0;
    wb0_hit   = '0;
    wb1_hit   = '0;
    for (int k = 0; k < NFLAG; k++) begin
      alloc_hit[k] = alloc_en && (alloc_tag_i == TAG_W'(k + 2));
      wb0_hit[k]   = wb0_en   && (wb0_tag_i   == TAG_W'(k + 2));
      wb1_hit[k]   = wb1_en   && (wb1_tag_i   == TAG_W'(k + 2));
    end
  end

  // Alloc beats a same-cycle completion; flush beats both. Error checks look at the
  // registered bit, i.e. the state before this cycle's update.
  always_comb begin
    done_d = done_q;
    err_d  = err_q;
    for (int k = 0; k < NFLAG; k++) begin
      if (flush_i) begin
        done_d[k] = 1'b1;
      end else if (alloc_hit[k]) begin
        done_d[k] = 1'b0;
      end else if (wb0_hit[k] || wb1_hit[k]) begin
        done_d[k] = 1'b1;
      end

      if ((wb0_hit[k] || wb1_hit[k]) && done_q[k]) err_d = 1'b1;
      if (wb0_hit[k] && wb1_hit[k])                err_d = 1'b1;
      if (alloc_hit[k] && !done_q[k])              err_d = 1'b1;
      if (alloc_hit[k] && (wb0_hit[k] || wb1_hit[k])) err_d = 1'b1;
    end
  end

  // Count is derived from the next vector so it lands on the same edge as the flags.
  always_comb begin
    cnt_d = '0;
    for (int k = 0; k < NFLAG; k++) begin
      cnt_d = cnt_d + {4'd0, ~done_d[k]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done_q <= '1;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      done_q <= done_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign done_flags_o    = done_q;
  assign pending_count_o = cnt_q;
  assign err_o           = err_q;

endmodule

// File: tb/tb_done_tracker.sv
// Directed scenarios then random traffic against a per-tag availability model.
module tb_done_tracker;

  logic        clk;
  logic        rst;
  logic        alloc_valid;
  logic [4:0]  alloc_tag;
  logic        wb0_valid;
  logic [4:0]  wb0_tag;
  logic        wb0_ready;
  logic        wb1_valid;
  logic [4:0]  wb1_tag;
  logic        wb1_ready;
  logic        flush;
  logic [29:0] done_flags;
  logic [4:0]  pending_count;
  logic        err;

  int checks;
  int failures;

  // Reference model: availability per architectural tag number.
  bit          avail_m[32];
  bit          err_m;
  logic [29:0] exp_q[$];

  done_tracker #(.TAG_W(5), .NFLAG(30)) dut (
    .clk            (clk),
    .rst            (rst),
    .alloc_valid_i  (alloc_valid),
    .alloc_tag_i    (alloc_tag),
    .wb0_valid_i    (wb0_valid),
    .wb0_tag_i      (wb0_tag),
    .wb0_ready_o    (wb0_ready),
    .wb1_valid_i    (wb1_valid),
    .wb1_tag_i      (wb1_tag),
    .wb1_ready_o    (wb1_ready),
    .flush_i        (flush),
    .done_flags_o   (done_flags),
    .pending_count_o(pending_count),
    .err_o          (err)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_update(input bit av, input int at, input bit v0, input int t0,
                              input bit v1, input int t1, input bit fl, input bit rs);
    logic [29:0] v;
    if (rs) begin
      for (int t = 0; t < 32; t++) avail_m[t] = 1'b1;
      err_m = 1'b0;
    end else if (fl) begin
      for (int t = 0; t < 32; t++) avail_m[t] = 1'b1;
    end else begin
      if (v0 && v1 && t0 == t1 && t0 >= 2) err_m = 1'b1;
      if (v0 && t0 >= 2 && (avail_m[t0] || (av && at == t0))) err_m = 1'b1;
      if (v1 && t1 >= 2 && (avail_m[t1] || (av && at == t1))) err_m = 1'b1;
      if (av && at >= 2 && !avail_m[at]) err_m = 1'b1;
      if (v0 && t0 >= 2) avail_m[t0] = 1'b1;
      if (v1 && t1 >= 2) avail_m[t1] = 1'b1;
      if (av && at >= 2) avail_m[at] = 1'b0;
    end
    for (int k = 0; k < 30; k++) v[k] = avail_m[k + 2];
    exp_q.push_back(v);
  endtask

  function automatic int model_pending();
    int n = 0;
    for (int t = 2; t < 32; t++) if (!avail_m[t]) n++;
    return n;
  endfunction

  // Driver task: one cycle of inputs, ready checked before the edge, state after it.
  task automatic step(input bit av, input int at, input bit v0, input int t0,
                      input bit v1, input int t1, input bit fl, input bit rs);
    logic [29:0] exp_flags;
    logic        exp_ready;
    @(negedge clk);
    alloc_valid = av;  alloc_tag = 5'(at);
    wb0_valid   = v0;  wb0_tag   = 5'(t0);
    wb1_valid   = v1;  wb1_tag   = 5'(t1);
    flush       = fl;  rst       = rs;
    #1;
    exp_ready = !(fl || rs);
    checks++;
    assert (wb0_ready === exp_ready) else begin
      failures++;
      $error("FAIL wb0_ready got=%b exp=%b", wb0_ready, exp_ready);
    end
    checks++;
    assert (wb1_ready === exp_ready) else begin
      failures++;
      $error("FAIL wb1_ready got=%b exp=%b", wb1_ready, exp_ready);
    end
    model_update(av, at, v0, t0, v1, t1, fl, rs);
    @(posedge clk);
    #1;
    exp_flags = exp_q.pop_front();
    checks++;
    assert (done_flags === exp_flags) else begin
      failures++;
      $error("FAIL done_flags got=%h exp=%h", done_flags, exp_flags);
    end
    checks++;
    assert (pending_count === 5'(model_pending())) else begin
      failures++;
      $error("FAIL pending_count got=%0d exp=%0d", pending_count, model_pending());
    end
    checks++;
    assert (err === err_m) else begin
      failures++;
      $error("FAIL err got=%b exp=%b", err, err_m);
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    err_m = 1'b0;
    for (int t = 0; t < 32; t++) avail_m[t] = 1'b1;
    rst = 1'b1; flush = 1'b0;
    alloc_valid = 1'b0; alloc_tag = '0;
    wb0_valid = 1'b0; wb0_tag = '0;
    wb1_valid = 1'b0; wb1_tag = '0;

    do_reset();
    do_reset();

    // Alloc 5 then complete it
    step(1, 5, 0, 0, 0, 0, 0, 0);
    checks++;
    assert (done_flags[3] === 1'b0 && pending_count === 5'd1) else begin
      failures++;
      $error("FAIL alloc5 got flag=%b cnt=%0d exp flag=0 cnt=1", done_flags[3], pending_count);
    end
    step(0, 0, 1, 5, 0, 0, 0, 0);

    // Two ports, distinct tags, same cycle
    do_reset();
    step(1, 2, 0, 0, 0, 0, 0, 0);
    step(1, 31, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 2, 1, 31, 0, 0);

    // Alloc/completion collision, err stays sticky
    do_reset();
    step(1, 7, 0, 0, 0, 0, 0, 0);
    step(1, 7, 0, 0, 1, 7, 0, 0);
    checks++;
    assert (done_flags[5] === 1'b0 && err === 1'b1) else begin
      failures++;
      $error("FAIL collide7 got flag=%b err=%b exp flag=0 err=1", done_flags[5], err);
    end
    for (int i = 0; i < 10; i++) idle();

    // Flush overrides same-cycle alloc and completion
    do_reset();
    for (int t = 3; t <= 12; t++) step(1, t, 0, 0, 0, 0, 0, 0);
    step(1, 20, 1, 4, 0, 0, 1, 0);
    idle();

    // Constant tags, then completion of a never-allocated tag
    do_reset();
    step(1, 1, 1, 0, 1, 1, 0, 0);
    step(0, 0, 1, 9, 0, 0, 0, 0);

    // Full allocation then reset mid-stream
    do_reset();
    for (int t = 2; t <= 31; t++) step(1, t, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 2, 0, 0, 0, 1);
    idle();

    // Random traffic
    do_reset();
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 1), $urandom_range(0, 31),
           $urandom_range(0, 1), $urandom_range(0, 31),
           $urandom_range(0, 1), $urandom_range(0, 31),
           $urandom_range(0, 19) == 0, $urandom_range(0, 63) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
